// File: rtl/axil_cfg_sequencer.sv
// Purpose: walks a register table, writes each entry over AXI4-Lite, writes 1 to the
//          accelerator control register, then polls it until ap_done (bit 1) is set.
// Latency: 1 fetch cycle + AW/W + B per entry; then ctrl write, AR/R polls spaced POLL_GAP cycles.
// Backpressure: every AXI VALID is held with stable payload until its own READY; BREADY/RREADY
//               are raised only while a response is awaited; one transaction in flight at a time.
// Ports: clk, reset_n (async, active low); start/num_entries request a run; tbl_idx/tbl_addr/
//        tbl_data read the parameter table; busy/done/error report status; AW/W/B/AR/R form an
//        AXI4-Lite master with 32-bit address and data.
module axil_cfg_sequencer #(
    parameter int          TBL_DEPTH = 16,
    parameter int          POLL_GAP  = 8,
    parameter logic [31:0] ADDR_CTRL = 32'h0,
    localparam int         IW        = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [IW:0]   num_entries,
    output logic [IW-1:0] tbl_idx,
    input  logic [31:0]   tbl_addr,
    input  logic [31:0]   tbl_data,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [31:0]   AWADDR,
    output logic          AWVALID,
    input  logic          AWREADY,
    output logic [31:0]   WDATA,
    output logic [3:0]    WSTRB,
    output logic          WVALID,
    input  logic          WREADY,
    input  logic [1:0]    BRESP,
    input  logic          BVALID,
    output logic          BREADY,
    output logic [31:0]   ARADDR,
    output logic          ARVALID,
    input  logic          ARREADY,
    input  logic [31:0]   RDATA,
    input  logic [1:0]    RRESP,
    input  logic          RVALID,
    output logic          RREADY
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WR_AW_W,
        S_WR_B,
        S_GO_AW_W,
        S_GO_B,
        S_POLL_AR,
        S_POLL_R,
        S_GAP
    } state_t;

    localparam logic [IW:0] DEPTH_C   = (IW+1)'(TBL_DEPTH);
    localparam logic [IW:0] IDX_ONE   = (IW+1)'(1);
    localparam logic [7:0]  GAP_INIT  = 8'(POLL_GAP - 1);
    localparam logic [31:0] CTRL_START = 32'h1;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    state_t      state;
    logic [IW:0] count;      // entries to write in the current run
    logic [7:0]  gap_cnt;    // remaining idle cycles between polls

    logic [IW:0] count_sat;
    logic [IW:0] idx_next;
    logic        aw_ok;
    logic        w_ok;

    // Only bit 1 (ap_done) of the status word matters.
    logic unused_rdata;
    assign unused_rdata = ^{RDATA[31:2], RDATA[0]};

    assign count_sat = (num_entries > DEPTH_C) ? DEPTH_C : num_entries;
    assign idx_next  = {1'b0, tbl_idx} + IDX_ONE;

    // A channel counts as finished once its VALID has dropped or is handshaking now.
    assign aw_ok = !AWVALID || AWREADY;
    assign w_ok  = !WVALID  || WREADY;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            count   <= '0;
            gap_cnt <= '0;
            tbl_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            AWADDR  <= '0;
            AWVALID <= 1'b0;
            WDATA   <= '0;
            WSTRB   <= '0;
            WVALID  <= 1'b0;
            BREADY  <= 1'b0;
            ARADDR  <= '0;
            ARVALID <= 1'b0;
            RREADY  <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // A start arriving in the same cycle as a done/error pulse is dropped,
                    // so the pulse is never followed by busy on the next cycle.
                    if (start && !done && !error) begin
                        count   <= count_sat;
                        tbl_idx <= '0;
                        busy    <= 1'b1;
                        if (count_sat != '0) begin
                            state <= S_FETCH;
                        end else begin
                            AWADDR  <= ADDR_CTRL;
                            WDATA   <= CTRL_START;
                            WSTRB   <= 4'hF;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            state   <= S_GO_AW_W;
                        end
                    end
                end

                // tbl_idx changed on the edge entering this state; the table answer is
                // valid by the end of this single cycle.
                S_FETCH: begin
                    AWADDR  <= tbl_addr;
                    WDATA   <= tbl_data;
                    WSTRB   <= 4'hF;
                    AWVALID <= 1'b1;
                    WVALID  <= 1'b1;
                    state   <= S_WR_AW_W;
                end

                S_WR_AW_W: begin
                    if (AWVALID && AWREADY) AWVALID <= 1'b0;
                    if (WVALID && WREADY)   WVALID  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        BREADY <= 1'b1;
                        state  <= S_WR_B;
                    end
                end

                S_WR_B: begin
                    if (BVALID) begin
                        BREADY <= 1'b0;
                        if (BRESP != RESP_OKAY) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            tbl_idx <= idx_next[IW-1:0];
                            if (idx_next < count) begin
                                state <= S_FETCH;
                            end else begin
                                AWADDR  <= ADDR_CTRL;
                                WDATA   <= CTRL_START;
                                WSTRB   <= 4'hF;
                                AWVALID <= 1'b1;
                                WVALID  <= 1'b1;
                                state   <= S_GO_AW_W;
                            end
                        end
                    end
                end

                S_GO_AW_W: begin
                    if (AWVALID && AWREADY) AWVALID <= 1'b0;
                    if (WVALID && WREADY)   WVALID  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        BREADY <= 1'b1;
                        state  <= S_GO_B;
                    end
                end

                S_GO_B: begin
                    if (BVALID) begin
                        BREADY <= 1'b0;
                        if (BRESP != RESP_OKAY) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            ARADDR  <= ADDR_CTRL;
                            ARVALID <= 1'b1;
                            state   <= S_POLL_AR;
                        end
                    end
                end

                S_POLL_AR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= S_POLL_R;
                    end
                end

                S_POLL_R: begin
                    if (RVALID) begin
                        RREADY <= 1'b0;
                        if (RRESP != RESP_OKAY) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else if (RDATA[1]) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= GAP_INIT;
                            state   <= S_GAP;
                        end
                    end
                end

                // Occupies exactly POLL_GAP cycles before the next read is issued.
                S_GAP: begin
                    if (gap_cnt == 8'd0) begin
                        ARVALID <= 1'b1;
                        state   <= S_POLL_AR;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axil_cfg_sequencer.md
AXIL_CFG_SEQUENCER -- requirements
Module: axil_cfg_sequencer

Interface
REQ-001 SHALL have parameter TBL_DEPTH, default 16, meaning max parameter-table entries (index width IW = clog2(TBL_DEPTH)).
REQ-002 SHALL have parameter POLL_GAP, default 8, meaning idle cycles between successive status polls (1..255).
REQ-003 SHALL have parameter ADDR_CTRL, default 32'h0, meaning accelerator control/status register address.
REQ-004 SHALL have ports:
- clk  in  1  sole clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to run a configuration sequence
- num_entries  in  IW+1  entries to write; sampled when start is accepted
- tbl_idx  out  IW  table read index
- tbl_addr  in  32  register address at tbl_idx; valid 1 cycle after tbl_idx changes
- tbl_data  in  32  register data at tbl_idx; same timing as tbl_addr
- busy  out  1  high from start acceptance until done/error
- done  out  1  one-cycle pulse: accelerator reported ap_done
- error  out  1  one-cycle pulse: non-OKAY response, sequence aborted
- AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  AXI4-Lite master, 32-bit address/data, standard directions

Function
REQ-005 SHALL implement states IDLE, FETCH, WR_AW_W, WR_B, GO_AW_W, GO_B, POLL_AR, POLL_R, GAP.
REQ-006 IDLE: start=1 -> latch num_entries, tbl_idx=0, busy=1; next FETCH if num_entries>0, else GO_AW_W. start while busy SHALL be ignored.
REQ-007 FETCH SHALL last exactly 1 cycle, then register tbl_addr/tbl_data into AWADDR/WDATA and enter WR_AW_W.
REQ-008 WR_AW_W SHALL assert AWVALID and WVALID together, WSTRB=4'hF; each VALID SHALL drop on the cycle after its own handshake (VALID&READY), independently; VALIDs SHALL NOT drop before handshake; AWADDR/WDATA stable while VALID.
REQ-009 Once both handshakes done -> WR_B with BREADY=1; on BVALID: BRESP!=0 -> error path (REQ-013); else tbl_idx+1, next FETCH if tbl_idx+1<latched count, else GO_AW_W.
REQ-010 GO_AW_W/GO_B SHALL write 32'h1 to ADDR_CTRL with the same handshake rules as REQ-008/009.
REQ-011 POLL_AR SHALL issue ARADDR=ADDR_CTRL with ARVALID until handshake; POLL_R SHALL hold RREADY=1 until RVALID.
REQ-012 On RVALID with RRESP=0: RDATA[1]=1 -> done pulse, busy=0, IDLE; else GAP for POLL_GAP cycles then POLL_AR.
REQ-013 Any BRESP or RRESP != 2'b00 SHALL pulse error for 1 cycle, clear busy, return IDLE; done SHALL NOT pulse.
REQ-014 At most one AXI transaction outstanding; ARVALID never asserted concurrently with AWVALID/WVALID.
REQ-015 BREADY and RREADY SHALL be 0 outside WR_B/GO_B and POLL_R respectively.
REQ-016 done and error SHALL be mutually exclusive and never asserted while busy=1 on the following cycle.
REQ-017 num_entries > TBL_DEPTH SHALL be saturated to TBL_DEPTH.

Reset
REQ-018 reset_n=0 SHALL asynchronously force state IDLE and all outputs to 0 (tbl_idx=0, all VALID/READY=0, AWADDR/ARADDR/WDATA/WSTRB=0, busy/done/error=0).
REQ-019 Reset mid-transaction SHALL abandon the transaction without completing handshakes; after release the block SHALL wait in IDLE for start.
REQ-020 No output SHALL change on the first clk edge after reset_n rises unless start=1.

Verification
REQ-021 Table {0x10:5, 0x14:7, 0x18:9}, num_entries=3, slave READY always 1, RDATA=0,0,2 -> three writes in order, write 0x0=1, three reads, done pulse once, busy high throughout.
REQ-022 AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 3 cycles with stable AWADDR, single B accepted.
REQ-023 num_entries=0 -> first AXI write is ADDR_CTRL=1; tbl_idx stays 0.
REQ-024 BRESP=2'b10 on second entry -> error pulse, no ADDR_CTRL write, busy=0, next start restarts at tbl_idx=0.
REQ-025 POLL_GAP=8, RDATA=0 twice then 2 -> ARVALID rising edges spaced ≥8 idle cycles apart, done after third read.
REQ-026 reset_n low during WR_AW_W with AWVALID=1 -> all outputs 0 same cycle (async); start after release -> clean sequence from entry 0.
